pll_reset_ctrl: RTL and testbench

Reset sequencer and lock supervisor that sits on the other side of the PLL wrapper. It drives the PLL's active-high `rst`, consumes its asynchronous `locked`, and releases the fabric's system reset only after lock has been stable for a programmed time. It detects loss of lock, retries with a timeout, and reports failure. It runs on the free-running reference clock, not on the PLL output, so it keeps running while the PLL is unlocked.

---
 rtl/pll_reset_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// ----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Reset sequencer and lock supervisor for a PLL. Runs on the free-running
// reference clock. It pulses the PLL reset, waits for lock to be stable for a
// programmed number of samples, holds the fabric in reset for a while longer,
// then releases it. Loss of lock in RUN restarts the sequence. Repeated lock
// timeouts end in FAIL.
//
// Ports:
//   clk            in   reference clock, free-running
//   reset_n        in   asynchronous active-low reset
//   locked         in   PLL lock, asynchronous to clk
//   soft_reset_req in   single-cycle request to re-run the full sequence
//   pll_rst        out  PLL reset, active high, registered
//   sys_reset_n    out  fabric reset, active low, registered
//   ready          out  high only in RUN
//   fail           out  high only in FAIL
//   lock_loss_cnt  out  saturating count of lock losses seen in RUN
//
// Build option:
//   PLL_RESET_CTRL_LOSS_CNT_EN  when defined, lock_loss_cnt is a live
//                               saturating counter; otherwise it is tied to 0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_PLL_RST   | PLL held in reset for RST_CYCLES cycles
// S_WAIT_LOCK | waiting for STABLE_CYCLES consecutive lock samples, or timeout
// S_HOLD      | lock accepted, fabric still in reset for HOLD_CYCLES cycles
// S_RUN       | fabric released, watching for loss of lock
// S_FAIL      | retries exhausted, parked until reset_n or soft_reset_req
// ----------------------------------------------------------------------------
module pll_reset_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int STABLE_CYCLES = 64,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int HOLD_CYCLES   = 32,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             locked,
   input  logic             soft_reset_req,
   output logic             pll_rst,
   output logic             sys_reset_n,
   output logic             ready,
   output logic             fail,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   // One phase counter is shared by the timed states, so it is sized for the
   // longest of them.
   localparam int PH_MAX_A = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
   localparam int PH_MAX   = (PH_MAX_A > LOCK_TIMEOUT) ? PH_MAX_A : LOCK_TIMEOUT;
   localparam int PH_W     = $clog2(PH_MAX + 1);
   localparam int ST_W     = $clog2(STABLE_CYCLES + 1);
   localparam int RT_W     = $clog2(MAX_RETRIES + 2);

   localparam logic [PH_W-1:0] RST_TC  = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0] TO_TC   = PH_W'(LOCK_TIMEOUT - 1);
   localparam logic [PH_W-1:0] HOLD_TC = PH_W'(HOLD_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_TC   = ST_W'(STABLE_CYCLES - 1);
   // Retry count before this timeout is counted; reaching it means the
   // incremented count equals MAX_RETRIES.
   localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_HOLD      = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            sync_1;
   logic            lock_s;
   logic [PH_W-1:0] ph_cnt;
   logic [ST_W-1:0] stable_cnt;
   logic [RT_W-1:0] retry_cnt;
   logic            retry_clr;
   logic            retry_inc;
   logic            entering;
   logic            pll_rst_nxt;
   logic            sys_reset_n_nxt;
   logic            ready_nxt;
   logic            fail_nxt;

   // ---------------------------------------------------------------------
   // Lock synchronizer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync_1 <= locked;
         lock_s <= sync_1;
      end
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_PLL_RST;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      retry_clr = 1'b0;
      retry_inc = 1'b0;
      if (soft_reset_req) begin
         state_nxt = S_PLL_RST;
         retry_clr = 1'b1;
      end else begin
         case (state)
            S_PLL_RST: begin
               if (ph_cnt == RST_TC) begin
                  state_nxt = S_WAIT_LOCK;
               end
            end
            S_WAIT_LOCK: begin
               // Accepting lock wins over a timeout landing on the same cycle.
               if (lock_s && (stable_cnt == ST_TC)) begin
                  state_nxt = S_HOLD;
                  retry_clr = 1'b1;
               end else if (ph_cnt == TO_TC) begin
                  retry_inc = 1'b1;
                  state_nxt = (retry_cnt == RT_LAST) ? S_FAIL : S_PLL_RST;
               end
            end
            S_HOLD: begin
               if (!lock_s) begin
                  state_nxt = S_PLL_RST;
               end else if (ph_cnt == HOLD_TC) begin
                  state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_nxt = S_PLL_RST;
               end
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: begin
               state_nxt = S_PLL_RST;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, so registered outputs change on the
   // same edge that enters the new state.
   // ---------------------------------------------------------------------
   always_comb begin
      pll_rst_nxt     = 1'b0;
      sys_reset_n_nxt = 1'b0;
      ready_nxt       = 1'b0;
      fail_nxt        = 1'b0;
      case (state_nxt)
         S_PLL_RST: pll_rst_nxt = 1'b1;
         S_RUN: begin
            sys_reset_n_nxt = 1'b1;
            ready_nxt       = 1'b1;
         end
         S_FAIL:    fail_nxt = 1'b1;
         default: begin
            pll_rst_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pll_rst     <= 1'b1;
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         pll_rst     <= pll_rst_nxt;
         sys_reset_n <= sys_reset_n_nxt;
         ready       <= ready_nxt;
         fail        <= fail_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Counters
   // ---------------------------------------------------------------------
   // A soft request re-enters PLL_RST even from PLL_RST itself.
   assign entering = soft_reset_req || (state_nxt != state);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph_cnt <= '0;
      end else if (entering) begin
         ph_cnt <= '0;
      end else if ((state == S_PLL_RST) || (state == S_WAIT_LOCK) || (state == S_HOLD)) begin
         ph_cnt <= ph_cnt + PH_W'(1);
      end
   end

   // Run length of consecutive lock samples, counted only inside WAIT_LOCK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_cnt <= '0;
      end else if ((state == S_WAIT_LOCK) && !entering && lock_s) begin
         stable_cnt <= stable_cnt + ST_W'(1);
      end else begin
         stable_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry_cnt <= '0;
      end else if (retry_clr) begin
         retry_cnt <= '0;
      end else if (retry_inc) begin
         retry_cnt <= retry_cnt + RT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Lock loss counter
   // ---------------------------------------------------------------------
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
   logic             loss_evt;
   logic [CNT_W-1:0] loss_cnt;

   // A soft request in the same cycle takes priority and is not a loss.
   assign loss_evt = (state == S_RUN) && !lock_s && !soft_reset_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt <= '0;
      end else if (loss_evt && (loss_cnt != {CNT_W{1'b1}})) begin
         loss_cnt <= loss_cnt + CNT_W'(1);
      end
   end

   assign lock_loss_cnt = loss_cnt;
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
module tb_pll_reset_ctrl;

   localparam int RST_C = 4;
   localparam int STB_C = 8;
   localparam int HLD_C = 4;
   localparam int TO_C  = 32;
   localparam int MAX_R = 2;
   localparam int CW    = 2;
   localparam int SAT   = (1 << CW) - 1;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_HOLD = 2;
   localparam int P_RUN  = 3;
   localparam int P_FAIL = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          locked = 1'b0;
   logic          soft_reset_req = 1'b0;
   logic          pll_rst;
   logic          sys_reset_n;
   logic          ready;
   logic          fail;
   logic [CW-1:0] lock_loss_cnt;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   pll_reset_ctrl #(
      .RST_CYCLES   (RST_C),
      .STABLE_CYCLES(STB_C),
      .LOCK_TIMEOUT (TO_C),
      .HOLD_CYCLES  (HLD_C),
      .MAX_RETRIES  (MAX_R),
      .CNT_W        (CW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .locked        (locked),
      .soft_reset_req(soft_reset_req),
      .pll_rst       (pll_rst),
      .sys_reset_n   (sys_reset_n),
      .ready         (ready),
      .fail          (fail),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int exp_loss(input int n);
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
      return (n > SAT) ? SAT : n;
`else
      return 0;
`endif
   endfunction

   function automatic logic [CW+3:0] expect_of(input int p, input int l);
      logic [CW-1:0] c;
      c = CW'(exp_loss(l));
      return {p == P_RST, p == P_RUN, p == P_RUN, p == P_FAIL, c};
   endfunction

   // ---------------------------------------------------------------------
   // Reference model: phase name, time spent in the phase, and run length of
   // high lock samples. lock_s is the locked sample from two edges earlier.
   // ---------------------------------------------------------------------
   int ph = P_RST;
   int age = 0;
   int run_hi = 0;
   int tries = 0;
   int losses = 0;
   bit dq[$] = '{1'b0, 1'b0};
   logic [CW+3:0] exp_q[$];

   task automatic enter(input int p);
      ph = p;
      age = 0;
      run_hi = 0;
   endtask

   always @(posedge clk) begin
      bit ls;
      if (!reset_n) begin
         enter(P_RST);
         tries = 0;
         losses = 0;
         dq = '{1'b0, 1'b0};
      end else begin
         ls = dq.pop_front();
         dq.push_back(locked);
         if (soft_reset_req) begin
            enter(P_RST);
            tries = 0;
         end else begin
            case (ph)
               P_RST: begin
                  age++;
                  if (age == RST_C) enter(P_WAIT);
               end
               P_WAIT: begin
                  age++;
                  run_hi = ls ? run_hi + 1 : 0;
                  if (run_hi == STB_C) begin
                     enter(P_HOLD);
                     tries = 0;
                  end else if (age == TO_C) begin
                     tries++;
                     enter((tries == MAX_R) ? P_FAIL : P_RST);
                  end
               end
               P_HOLD: begin
                  if (!ls) enter(P_RST);
                  else begin
                     age++;
                     if (age == HLD_C) enter(P_RUN);
                  end
               end
               P_RUN: begin
                  if (!ls) begin
                     losses++;
                     enter(P_RST);
                  end
               end
               default: ;
            endcase
         end
      end
      exp_q.push_back(expect_of(ph, losses));
   end

   // Monitor: one expected output word per clock, compared mid-cycle.
   always @(negedge clk) begin
      logic [CW+3:0] e;
      logic [CW+3:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pll_rst, sys_reset_n, ready, fail, lock_loss_cnt};
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL scoreboard cyc=%0d {pll_rst,sys_reset_n,ready,fail,cnt} got=%b expected=%b",
                     cyc, a, e);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // which: 0 ready, 1 pll_rst, 2 fail, 3 model in HOLD. dt = edges waited.
   task automatic wait_sig(input int which, input int bound, output int dt);
      int t0;
      bit hit;
      t0 = cyc;
      hit = 1'b0;
      dt = -1;
      for (int i = 0; i < bound && !hit; i++) begin
         @(negedge clk);
         case (which)
            0: hit = ready;
            1: hit = pll_rst;
            2: hit = fail;
            default: hit = (ph == P_HOLD);
         endcase
         if (hit) dt = cyc - t0;
      end
      if (!hit) begin
         compared++;
         mismatched++;
         $display("FAIL wait_%0d: no event within %0d cycles", which, bound);
      end
   endtask

   task automatic pulse_soft();
      soft_reset_req = 1'b1;
      @(negedge clk);
      soft_reset_req = 1'b0;
   endtask

   initial begin
      int dt;
      int t_soft;
      int run_len;
      logic [CW+3:0] rst_vec;
      rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};

      // Reset values, locked already high for the bring-up.
      locked = 1'b1;
      #1 reset_n = 1'b0;
      #2 check("reset_values", int'({pll_rst, sys_reset_n, ready, fail, lock_loss_cnt}), int'(rst_vec));
      repeat (3) @(negedge clk);

      // Normal bring-up: minimum latency with lock already present.
      reset_n = 1'b1;
      wait_sig(0, 100, dt);
      check("bringup_latency", dt, RST_C + STB_C + HLD_C);
      check("bringup_sys_reset_n", int'(sys_reset_n), 1);
      check("bringup_fail", int'(fail), 0);

      // Glitchy lock: one low sample after 5 WAIT_LOCK edges. Through the
      // 2-stage delay the low reaches the sequencer after 7 counted highs,
      // so no lock is accepted and a full window must follow.
      pulse_soft();
      t_soft = cyc;
      repeat (RST_C + 5) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      wait_sig(0, 100, dt);
      check("glitch_ready_edge", cyc - t_soft, RST_C + 7 + 1 + STB_C + HLD_C);

      // Lock loss in RUN, repeated past saturation.
      for (int i = 0; i < 6; i++) begin
         locked = 1'b0;
         wait_sig(1, 20, dt);
         if (i == 0) begin
            check("loss_to_pll_rst", dt, 3);
            check("loss_sys_reset_n", int'(sys_reset_n), 0);
         end
         locked = 1'b1;
         wait_sig(0, 100, dt);
         if (i == 0) check("loss_cnt_one", int'(lock_loss_cnt), exp_loss(1));
      end
      check("loss_cnt_sat", int'(lock_loss_cnt), exp_loss(6));

      // Never locks: two full attempts, then FAIL; soft request recovers.
      locked = 1'b0;
      pulse_soft();
      t_soft = cyc;
      wait_sig(2, 200, dt);
      check("fail_edge", cyc - t_soft, MAX_R * (RST_C + TO_C));
      check("fail_pll_rst", int'(pll_rst), 0);
      check("fail_sys_reset_n", int'(sys_reset_n), 0);
      pulse_soft();
      check("soft_exit_fail", int'(fail), 0);
      check("soft_exit_pll_rst", int'(pll_rst), 1);

      // Randomized lock behaviour with occasional soft requests.
      run_len = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (run_len == 0) begin
            locked = ($urandom_range(0, 3) != 0);
            if (locked) run_len = $urandom_range(1, 60);
            else if ($urandom_range(0, 7) == 0) run_len = $urandom_range(30, 90);
            else run_len = $urandom_range(1, 6);
         end
         run_len--;
         soft_reset_req = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      soft_reset_req = 1'b0;

      // Asynchronous reset in the middle of HOLD.
      locked = 1'b1;
      pulse_soft();
      wait_sig(3, 100, dt);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset_hold", int'({pll_rst, sys_reset_n, ready, fail, lock_loss_cnt}), int'(rst_vec));
      @(negedge clk);
      reset_n = 1'b1;
      wait_sig(0, 100, dt);
      check("rebringup_latency", dt, RST_C + STB_C + HLD_C);
      check("rebringup_cnt_cleared", int'(lock_loss_cnt), 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
